// File: rtl/mips_bus_pkg.sv
// Shared CPU data-bus definitions: bus word type, word size, the poison value returned
// for rejected reads, and the responder handshake state type.
package mips_bus_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef logic [31:0] bus_word_t;

  localparam bus_word_t BAD_READ_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StAck  = 2'd2
  } resp_state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane merge for partial-word stores. Shared with the CPU store path.
// Ports:
//   old_word    - current word contents
//   new_word    - store data
//   byteenable  - bit i selects byte i of new_word
//   merged_word - old_word with the enabled bytes replaced by new_word
module byte_lane_merge
  import mips_bus_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  byteenable,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byteenable[i]) begin
        merged_word[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/avalon_data_responder.sv
// Avalon-MM data responder: on-chip data RAM behind the CPU data port, with a fixed number
// of wait states per access. Every access stalls WAIT_CYCLES+1 cycles and completes in the
// single ACK cycle that follows; request inputs are latched when the access starts.
//
// Ports:
//   clk, reset_n          - clock (rising edge), asynchronous active-low reset
//   address               - byte address; word index = ((address - BASE_ADDR) >> 2) mod DEPTH
//   read, write           - requests; both high is a write
//   byteenable, writedata - write lanes and data
//   waitrequest           - high while a request is pending and not in ACK
//   readdata              - last completed read, held until the next read completes
//   err                   - sticky access error (0 unless the address check is built in)
//
// Build option: define DATA_RESP_ADDR_CHECK_EN to reject misaligned, out-of-range and
// read+write accesses (no write, readdata = BAD_READ_DATA, err set until reset).
module avalon_data_responder
  import mips_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  resp_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            wr_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            bad_q, bad_d;
  logic [31:0]     readdata_q;
  logic [31:0]     word_off;
  logic [31:0]     merged;
  logic            req, start, commit_wr;

  logic [31:0] mem [DEPTH];

  assign req   = read | write;
  assign start = (state_q == StIdle) && req;

  // 32-bit unsigned subtraction: addresses below BASE_ADDR wrap around.
  assign word_off = (address - BASE_ADDR) >> 2;
  assign idx_d    = IdxW'(word_off % 32'(DEPTH));

`ifdef DATA_RESP_ADDR_CHECK_EN
  assign bad_d = (address[1:0] != 2'b00) || (word_off >= 32'(DEPTH)) || (read && write);
`else
  assign bad_d = 1'b0;
`endif

  assign waitrequest = req && (state_q != StAck);
  assign readdata    = readdata_q;
  assign commit_wr   = (state_q == StAck) && wr_q && !bad_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StAck;
          end else begin
            cnt_d   = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // A request withdrawn mid-stall abandons the access with no side effects.
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      bad_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        idx_q   <= idx_d;
        wr_q    <= write;
        be_q    <= byteenable;
        wdata_q <= writedata;
        bad_q   <= bad_d;
      end
      if ((state_q == StAck) && !wr_q) begin
        readdata_q <= bad_q ? BAD_READ_DATA : mem[idx_q];
      end
    end
  end

`ifdef DATA_RESP_ADDR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if ((state_q == StAck) && bad_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  byte_lane_merge u_merge (
    .old_word    (mem[idx_q]),
    .new_word    (wdata_q),
    .byteenable  (be_q),
    .merged_word (merged)
  );

  // Storage is not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[idx_q] <= merged;
    end
  end

endmodule

// File: tb/tb_avalon_data_responder.sv
// Bench for avalon_data_responder: instance 0 has two wait states, instance 1 has none.
// A request-level model tracks memory, readdata, err and the expected waitrequest for
// every cycle; a single compare process checks both instances on each falling edge.
module tb_avalon_data_responder;

  localparam int unsigned Depth = 64;
  localparam logic [31:0] Base  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s[2];
  logic [3:0]  be_s   [2];
  logic        wreq_o [2];
  logic        err_o  [2];
  logic [31:0] rdata_o[2];

  logic [31:0] mm     [2][Depth];
  logic        exp_wr [2];
  logic        exp_err[2];
  logic [31:0] exp_rd [2];

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  always #5 clk = ~clk;

  avalon_data_responder #(
    .DEPTH       (Depth),
    .BASE_ADDR   (Base),
    .WAIT_CYCLES (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (addr_s[0]),
    .read        (rd_s[0]),
    .write       (wr_s[0]),
    .byteenable  (be_s[0]),
    .writedata   (wdata_s[0]),
    .waitrequest (wreq_o[0]),
    .readdata    (rdata_o[0]),
    .err         (err_o[0])
  );

  avalon_data_responder #(
    .DEPTH       (Depth),
    .BASE_ADDR   (Base),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (addr_s[1]),
    .read        (rd_s[1]),
    .write       (wr_s[1]),
    .byteenable  (be_s[1]),
    .writedata   (wdata_s[1]),
    .waitrequest (wreq_o[1]),
    .readdata    (rdata_o[1]),
    .err         (err_o[1])
  );

  function automatic int lat(int k);
    return (k == 0) ? 2 : 0;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (wreq_o[k] !== exp_wr[k]) begin
          mismatched++;
          $display("FAIL waitrequest[%0d] t=%0t got %b want %b", k, $time, wreq_o[k], exp_wr[k]);
        end
        compared++;
        if (rdata_o[k] !== exp_rd[k]) begin
          mismatched++;
          $display("FAIL readdata[%0d] t=%0t got %h want %h", k, $time, rdata_o[k], exp_rd[k]);
        end
        compared++;
        if (err_o[k] !== exp_err[k]) begin
          mismatched++;
          $display("FAIL err[%0d] t=%0t got %b want %b", k, $time, err_o[k], exp_err[k]);
        end
      end
    end
  end

  task automatic check32(string name, logic [31:0] got, logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called just after a rising edge. Returns just after the completion edge with the
  // request still asserted, so the caller may chain another access or call idle().
  task automatic access(int k, bit w, bit r, logic [31:0] a, logic [3:0] be, logic [31:0] d);
    logic [31:0] off;
    int          idx;
    bit          bad;
    off = a - Base;
    idx = int'((off >> 2) % Depth);
    bad = 1'b0;
`ifdef DATA_RESP_ADDR_CHECK_EN
    bad = (a[1:0] != 2'b00) || ((off >> 2) >= Depth) || (w && r);
`endif
    wr_s[k] = w; rd_s[k] = r; addr_s[k] = a; be_s[k] = be; wdata_s[k] = d;
    exp_wr[k] = 1'b1;
    for (int n = 0; n < lat(k); n++) begin
      @(posedge clk); #1;
      addr_s[k] = $urandom; wdata_s[k] = $urandom; be_s[k] = 4'($urandom);
    end
    @(posedge clk); #1;
    addr_s[k] = $urandom; wdata_s[k] = $urandom; be_s[k] = 4'($urandom);
    exp_wr[k] = 1'b0;
    @(posedge clk); #1;
    if (w) begin
      if (!bad) begin
        for (int i = 0; i < 4; i++) if (be[i]) mm[k][idx][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      exp_rd[k] = bad ? 32'hDEAD_BEEF : mm[k][idx];
    end
    if (bad) exp_err[k] = 1'b1;
    exp_wr[k] = 1'b1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = 1'b0; wr_s[k] = 1'b0; exp_wr[k] = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = 0; wr_s[k] = 0; addr_s[k] = Base; wdata_s[k] = 0; be_s[k] = 0;
      exp_wr[k] = 0; exp_err[k] = 0; exp_rd[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check32("reset readdata", rdata_o[0], 32'h0);
    check32("reset waitrequest", 32'(wreq_o[0]), 32'h0);

    // Full write, read back.
    access(0, 1, 0, 32'h1000, 4'hF, 32'hCAFE_BABE); idle();
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0);
    check32("read after full write", rdata_o[0], 32'hCAFE_BABE);
    idle();

    // Byte-lane merges, back to back.
    access(0, 1, 0, 32'h1000, 4'b0001, 32'h0000_0011);
    access(0, 1, 0, 32'h1000, 4'b1000, 32'h2200_0000);
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0);
    check32("byte merge", rdata_o[0], 32'h22FE_BA11);
    idle();

    // Empty byteenable changes nothing.
    access(0, 1, 0, 32'h1000, 4'h0, 32'hFFFF_FFFF); idle();
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0);
    check32("be zero write", rdata_o[0], 32'h22FE_BA11);
    idle();

    // Write withdrawn during the stall.
    wr_s[0] = 1; addr_s[0] = 32'h1000; wdata_s[0] = 32'h0; be_s[0] = 4'hF; exp_wr[0] = 1;
    @(posedge clk); #1;
    wr_s[0] = 0; exp_wr[0] = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0);
    check32("dropped write", rdata_o[0], 32'h22FE_BA11);
    idle();

    // Misaligned read.
    access(0, 0, 1, 32'h1002, 4'h0, 32'h0); idle();
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0); idle();
`ifdef DATA_RESP_ADDR_CHECK_EN
    access(0, 0, 1, 32'h1002, 4'h0, 32'h0);
    check32("misaligned read", rdata_o[0], 32'hDEAD_BEEF);
    idle();
    check32("err sticky", 32'(err_o[0]), 32'h1);
`else
    access(0, 0, 1, 32'h1002, 4'h0, 32'h0);
    check32("misaligned read", rdata_o[0], 32'h22FE_BA11);
    idle();
    check32("err tied low", 32'(err_o[0]), 32'h0);
`endif

    // One past the top wraps to word 0.
    access(0, 1, 0, Base + 4 * Depth, 4'hF, 32'hA5A5_A5A5); idle();
    access(0, 0, 1, 32'h1000, 4'h0, 32'h0);
`ifdef DATA_RESP_ADDR_CHECK_EN
    check32("alias write", rdata_o[0], 32'h22FE_BA11);
`else
    check32("alias write", rdata_o[0], 32'hA5A5_A5A5);
`endif
    idle();

    // Reset during the stall of a write.
    access(0, 1, 0, 32'h1008, 4'hF, 32'h1111_1111); idle();
    wr_s[0] = 1; addr_s[0] = 32'h1008; wdata_s[0] = 32'h1234_5678; be_s[0] = 4'hF;
    exp_wr[0] = 1;
    @(posedge clk); #1;
    reset_n = 1'b0; wr_s[0] = 0; exp_wr[0] = 0;
    for (int k = 0; k < 2; k++) begin
      exp_rd[k] = 0; exp_err[k] = 0;
    end
    @(posedge clk); #1;
    check32("readdata in reset", rdata_o[0], 32'h0);
    check32("waitrequest in reset", 32'(wreq_o[0]), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    access(0, 0, 1, 32'h1008, 4'h0, 32'h0);
    check32("aborted write", rdata_o[0], 32'h1111_1111);
    idle();

    // Zero wait states: back-to-back reads.
    access(1, 1, 0, 32'h1000, 4'hF, 32'h0102_0304);
    access(1, 1, 0, 32'h1004, 4'hF, 32'h0506_0708);
    idle();
    access(1, 0, 1, 32'h1000, 4'h0, 32'h0);
    check32("w0 read 1000", rdata_o[1], 32'h0102_0304);
    access(1, 0, 1, 32'h1004, 4'h0, 32'h0);
    check32("w0 read 1004", rdata_o[1], 32'h0506_0708);
    idle();

    // Read and write together.
    access(1, 1, 1, 32'h1004, 4'hF, 32'hAAAA_5555); idle();
    access(1, 0, 1, 32'h1004, 4'h0, 32'h0);
`ifdef DATA_RESP_ADDR_CHECK_EN
    check32("read+write", rdata_o[1], 32'h0506_0708);
`else
    check32("read+write", rdata_o[1], 32'hAAAA_5555);
`endif
    idle();
    idle();

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
